// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed-priority or round-robin selection, grant held
// until transaction_done or a programmable BUSY-cycle timeout.
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 4,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 16,
  parameter int GRANT_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic                   transaction_done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [GRANT_W-1:0]     bus_grant,
  output logic                   busy,
  output logic                   timeout_flag
);

  // state | meaning
  // IDLE  | bus free, arbitrating on any request
  // BUSY  | bus owned by r_bus_grant until done or timeout
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam int                 CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_MASTERS - 1);

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [GRANT_W-1:0]     r_bus_grant;
  logic                   r_busy;
  logic                   r_timeout_flag;
  logic [CNT_W-1:0]       r_cnt;
  logic [GRANT_W-1:0]     r_last;

  state_t                 w_state_nxt;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [GRANT_W-1:0]     w_bus_grant_nxt;
  logic                   w_busy_nxt;
  logic                   w_timeout_flag_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [GRANT_W-1:0]     w_last_nxt;

  logic                   w_found;
  logic [GRANT_W-1:0]     w_winner;
  logic [NUM_MASTERS-1:0] w_winner_oh;

  // Round-robin scans from last+1 with a single wrap subtraction, so no
  // modulo hardware is needed for non-power-of-two master counts.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (RR_MODE != 0) begin
        idx = int'(r_last) + 1 + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      end else begin
        idx = k;
      end
      if (!w_found && request[idx]) begin
        w_found  = 1'b1;
        w_winner = GRANT_W'(idx);
      end
    end
  end

  assign w_winner_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_winner;

  always_comb begin
    w_state_nxt        = r_state;
    w_grant_nxt        = r_grant;
    w_bus_grant_nxt    = r_bus_grant;
    w_busy_nxt         = r_busy;
    w_timeout_flag_nxt = 1'b0;
    w_cnt_nxt          = r_cnt;
    w_last_nxt         = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt     = S_BUSY;
          w_grant_nxt     = w_winner_oh;
          w_bus_grant_nxt = w_winner;
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = '0;
          w_last_nxt      = w_winner;
        end
      end
      S_BUSY: begin
        if (transaction_done) begin
          w_state_nxt     = S_IDLE;
          w_grant_nxt     = '0;
          w_bus_grant_nxt = '0;
          w_busy_nxt      = 1'b0;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_MAX)) begin
          w_state_nxt        = S_IDLE;
          w_grant_nxt        = '0;
          w_bus_grant_nxt    = '0;
          w_busy_nxt         = 1'b0;
          w_timeout_flag_nxt = 1'b1;
        end else if (TIMEOUT != 0) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_grant_nxt     = '0;
        w_bus_grant_nxt = '0;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_grant        <= '0;
      r_bus_grant    <= '0;
      r_busy         <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_cnt          <= '0;
      r_last         <= LAST_RST;
    end else begin
      r_state        <= w_state_nxt;
      r_grant        <= w_grant_nxt;
      r_bus_grant    <= w_bus_grant_nxt;
      r_busy         <= w_busy_nxt;
      r_timeout_flag <= w_timeout_flag_nxt;
      r_cnt          <= w_cnt_nxt;
      r_last         <= w_last_nxt;
    end
  end

  assign grant        = r_grant;
  assign bus_grant    = r_bus_grant;
  assign busy         = r_busy;
  assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: three configurations share one stimulus stream and
// are checked every cycle against an ownership-level model, plus directed pins.
module tb_bus_arbiter_n;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  logic [3:0] d_grant [3];
  logic [1:0] d_bg    [3];
  logic       d_busy  [3];
  logic       d_tf    [3];

  int total = 0;
  int bad   = 0;

  // instance 0: round-robin, long timeout; 1: fixed priority; 2: round-robin, timeout 4
  bus_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .TIMEOUT(16)) u_rr (
    .clk(clk), .reset(rst), .request(req), .transaction_done(done),
    .grant(d_grant[0]), .bus_grant(d_bg[0]), .busy(d_busy[0]), .timeout_flag(d_tf[0]));
  bus_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(0), .TIMEOUT(16)) u_fp (
    .clk(clk), .reset(rst), .request(req), .transaction_done(done),
    .grant(d_grant[1]), .bus_grant(d_bg[1]), .busy(d_busy[1]), .timeout_flag(d_tf[1]));
  bus_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .TIMEOUT(4)) u_to (
    .clk(clk), .reset(rst), .request(req), .transaction_done(done),
    .grant(d_grant[2]), .bus_grant(d_bg[2]), .busy(d_busy[2]), .timeout_flag(d_tf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int owner;   // -1 when the bus is free
    int held;    // busy cycles spent by the current owner
    int last;    // most recently granted master
    bit flag;
  } mst_t;

  mst_t m [3];

  function automatic int rr_of(int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int to_of(int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic mst_t step(mst_t s, int i, logic [3:0] r, logic d);
    mst_t n;
    int   pick;
    int   mm;
    n      = s;
    n.flag = 1'b0;
    pick   = -1;
    if (s.owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        mm = (rr_of(i) != 0) ? (s.last + 1 + k) % 4 : k;
        if (pick < 0 && r[mm]) pick = mm;
      end
      if (pick >= 0) begin
        n.owner = pick;
        n.last  = pick;
        n.held  = 1;
      end
    end else if (d) begin
      n.owner = -1;
    end else if (to_of(i) > 0 && s.held == to_of(i)) begin
      n.owner = -1;
      n.flag  = 1'b1;
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) m[i] <= '{owner: -1, held: 0, last: 3, flag: 1'b0};
    end else begin
      for (int i = 0; i < 3; i++) m[i] <= step(m[i], i, req, done);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model%0d grant", i), {28'd0, d_grant[i]},
          (m[i].owner < 0) ? 32'd0 : (32'd1 << m[i].owner));
      chk($sformatf("model%0d bus_grant", i), {30'd0, d_bg[i]},
          (m[i].owner < 0) ? 32'd0 : m[i].owner);
      chk($sformatf("model%0d busy", i), {31'd0, d_busy[i]}, {31'd0, (m[i].owner >= 0)});
      chk($sformatf("model%0d timeout_flag", i), {31'd0, d_tf[i]}, {31'd0, m[i].flag});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
  endtask

  task automatic wait_busy(input int inst, input string nm);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_busy[inst] === 1'b1) break;
    end
    chk(nm, {31'd0, d_busy[inst]}, 32'd1);
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int cnt;

  initial begin
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;

    // reset and basic grant
    repeat (2) @(negedge clk);
    chk("reset grant", {28'd0, d_grant[0]}, 32'd0);
    chk("reset bus_grant", {30'd0, d_bg[0]}, 32'd0);
    chk("reset busy", {31'd0, d_busy[0]}, 32'd0);
    chk("reset timeout_flag", {31'd0, d_tf[0]}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    chk("basic grant", {28'd0, d_grant[0]}, 32'h4);
    chk("basic bus_grant", {30'd0, d_bg[0]}, 32'd2);
    chk("basic busy", {31'd0, d_busy[0]}, 32'd1);
    chk("basic grant fp", {28'd0, d_grant[1]}, 32'h4);

    // grant hold while owner drops its request
    req = 4'b1001;
    repeat (5) begin
      @(negedge clk);
      chk("hold grant", {28'd0, d_grant[0]}, 32'h4);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("hold release", {31'd0, d_busy[0]}, 32'd0);
    @(negedge clk);
    chk("hold next grant", {28'd0, d_grant[0]}, 32'h8);
    chk("hold next bus_grant", {30'd0, d_bg[0]}, 32'd3);

    // round-robin rotation
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_busy(0, "rr wait grant");
      chk($sformatf("rr order %0d", i), {30'd0, d_bg[0]}, rr_exp[i]);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("rr idle gap", {31'd0, d_busy[0]}, 32'd0);
    end

    // fixed priority
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      wait_busy(1, "fp wait grant");
      chk("fp winner", {30'd0, d_bg[1]}, 32'd1);
      chk("fp master3 never", {31'd0, d_grant[1][3]}, 32'd0);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end

    // timeout, then done on the last allowed cycle
    do_reset();
    req = 4'b0001;
    wait_busy(2, "to wait grant");
    req = 4'b0000;
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_busy[2] !== 1'b1) break;
      cnt++;
    end
    chk("to busy cycles", cnt, 32'd4);
    chk("to flag set", {31'd0, d_tf[2]}, 32'd1);
    @(negedge clk);
    chk("to flag one cycle", {31'd0, d_tf[2]}, 32'd0);
    req = 4'b0001;
    wait_busy(2, "to2 wait grant");
    req = 4'b0000;
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("to2 released", {31'd0, d_busy[2]}, 32'd0);
    chk("to2 no flag", {31'd0, d_tf[2]}, 32'd0);

    // asynchronous reset mid-transaction
    do_reset();
    req = 4'b0010;
    wait_busy(0, "mid wait grant");
    chk("mid owner", {30'd0, d_bg[0]}, 32'd1);
    req = 4'b0000;
    #2 rst = 1'b0;
    #1;
    chk("mid async grant", {28'd0, d_grant[0]}, 32'd0);
    chk("mid async busy", {31'd0, d_busy[0]}, 32'd0);
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    chk("mid regrant", {30'd0, d_bg[0]}, 32'd0);
    chk("mid regrant busy", {31'd0, d_busy[0]}, 32'd1);

    // randomized traffic: frequent done, then sparse done to exercise timeouts
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      req  = 4'($urandom_range(0, 15));
      done = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
